alu_mul_sequencer: RTL

- Multi-cycle shift-add multiply engine with pipeline-stall controller, sitting beside the EX-stage ALU.
- Detects ALU control code 5 (multiply) on the issuing instruction, freezes the pipeline via stall_o, iterates one multiplier bit per cycle, then releases the stall with the product on result_o.
- Lets the single-cycle ALU drop its combinational multiplier while the other ALU codes (1:+, 2:-, 3:&, 4:|) stay single-cycle.

---
 rtl/alu_mul_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-add multiplier with pipeline-stall control for the EX-stage ALU.
// Optional build macro MUL_EARLY_TERM_EN ends RUN as soon as the remaining multiplier is zero.
module alu_mul_sequencer #(
    parameter int         WIDTH    = 32,
    parameter logic [2:0] MUL_CODE = 3'd5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             start;

    assign start = valid_i && (ALUCtrl_i == MUL_CODE) && (state_q == S_IDLE) && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = data1_i;
                    mplier_d = data2_i;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else
`ifdef MUL_EARLY_TERM_EN
                if (mplier_q == '0) begin
                    // No set bits remain: acc already holds the full product.
                    state_d  = S_DONE;
                    result_d = acc_q;
                end else
`endif
                begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + 1'b1;
                    // count_q == WIDTH-1 marks the WIDTH-th iteration.
                    if (count_q == LAST_CNT) begin
                        state_d  = S_DONE;
                        result_d = acc_d;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stall drops in DONE so the pipeline captures result_o that cycle.
    assign stall_o  = start || (state_q == S_RUN);
    assign busy_o   = (state_q == S_RUN);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

endmodule
